// File: rtl/led_tone_player.sv
// ============================================================================
//  led_tone_player
//  Plays one game step: lights a color LED with its buzzer tone for ON_TICKS
//  cycles, then holds a dark gap of OFF_TICKS cycles and pulses done.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module led_tone_player #(
  parameter int ON_TICKS   = 1000,
  parameter int OFF_TICKS  = 200,
  parameter int TONE_HALF0 = 4,
  parameter int TONE_HALF1 = 3,
  parameter int TONE_HALF2 = 2,
  parameter int TONE_HALF3 = 5
) (
  input  logic       clk_2k,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [1:0] color,
  input  logic       abort,
  output logic       ready,
  output logic [3:0] led,
  output logic       buzz,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] C_ON_LAST  = 16'(ON_TICKS - 1);
  localparam logic [15:0] C_OFF_LAST = 16'(OFF_TICKS - 1);
  localparam logic [7:0]  C_TH0_LAST = 8'(TONE_HALF0 - 1);
  localparam logic [7:0]  C_TH1_LAST = 8'(TONE_HALF1 - 1);
  localparam logic [7:0]  C_TH2_LAST = 8'(TONE_HALF2 - 1);
  localparam logic [7:0]  C_TH3_LAST = 8'(TONE_HALF3 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_phase_cnt;
  logic [7:0]  r_tone_cnt;
  logic [1:0]  r_color;
  logic        r_ready;
  logic [3:0]  r_led;
  logic        r_buzz;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_tone_last;
  logic        w_accept;

  assign w_accept = valid & r_ready & ~abort;

  always_comb begin
    w_tone_last = C_TH0_LAST;
    case (r_color)
      2'd1:    w_tone_last = C_TH1_LAST;
      2'd2:    w_tone_last = C_TH2_LAST;
      2'd3:    w_tone_last = C_TH3_LAST;
      default: w_tone_last = C_TH0_LAST;
    endcase
  end

  always_ff @(posedge clk_2k) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= 16'd0;
      r_tone_cnt  <= 8'd0;
      r_color     <= 2'd0;
      r_ready     <= 1'b1;
      r_led       <= 4'd0;
      r_buzz      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_ON;
            r_color     <= color;
            r_phase_cnt <= 16'd0;
            r_tone_cnt  <= 8'd0;
            r_led       <= 4'b0001 << color;
            r_buzz      <= 1'b0;
            r_busy      <= 1'b1;
            r_ready     <= 1'b0;
          end
        end
        S_ON: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= 16'd0;
            r_tone_cnt  <= 8'd0;
            r_led       <= 4'd0;
            r_buzz      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
          end else if (r_phase_cnt == C_ON_LAST) begin
            r_state     <= S_GAP;
            r_phase_cnt <= 16'd0;
            r_tone_cnt  <= 8'd0;
            r_led       <= 4'd0;
            r_buzz      <= 1'b0;
          end else begin
            r_phase_cnt <= r_phase_cnt + 16'd1;
            // Square wave: flip every TONE_HALF cycles of the latched color
            if (r_tone_cnt == w_tone_last) begin
              r_tone_cnt <= 8'd0;
              r_buzz     <= ~r_buzz;
            end else begin
              r_tone_cnt <= r_tone_cnt + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (abort || (r_phase_cnt == C_OFF_LAST)) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= 16'd0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= ~abort;
          end else begin
            r_phase_cnt <= r_phase_cnt + 16'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_phase_cnt <= 16'd0;
          r_tone_cnt  <= 8'd0;
          r_led       <= 4'd0;
          r_buzz      <= 1'b0;
          r_busy      <= 1'b0;
          r_ready     <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign led   = r_led;
  assign buzz  = r_buzz;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_led_tone_player.sv
// ============================================================================
//  tb_led_tone_player
//  Scoreboard bench: two instances (6/3 timing and 1/1 edge timing).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_tone_player;

  typedef struct {
    int         lbl;
    logic [3:0] led;
    logic       buzz;
    logic       busy;
    logic       ready;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       va, aa, vb, ab;
  logic [1:0] ca, cb;
  logic       ready_a, buzz_a, busy_a, done_a;
  logic       ready_b, buzz_b, busy_b, done_b;
  logic [3:0] led_a, led_b;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_a = 0;
  int   last_b = 0;
  int   mon_lbl;
  exp_t qa[$];
  exp_t qb[$];

  led_tone_player #(.ON_TICKS(6), .OFF_TICKS(3)) u_dut_a (
    .clk_2k(clk), .rst_n(rst_n), .valid(va), .color(ca), .abort(aa),
    .ready(ready_a), .led(led_a), .buzz(buzz_a), .busy(busy_a), .done(done_a)
  );

  led_tone_player #(
    .ON_TICKS(1), .OFF_TICKS(1),
    .TONE_HALF0(1), .TONE_HALF1(1), .TONE_HALF2(1), .TONE_HALF3(1)
  ) u_dut_b (
    .clk_2k(clk), .rst_n(rst_n), .valid(vb), .color(cb), .abort(ab),
    .ready(ready_b), .led(led_b), .buzz(buzz_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int on_ticks(input int d);
    return (d == 0) ? 6 : 1;
  endfunction

  function automatic int off_ticks(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int tone_half(input int d, input logic [1:0] c);
    if (d != 0) return 1;
    case (c)
      2'd0: return 4;
      2'd1: return 3;
      2'd2: return 2;
      default: return 5;
    endcase
  endfunction

  // Label L = outputs visible after edge L-1 (i.e. what edge L samples)
  task automatic push(input int d, input int lbl, input logic [3:0] led,
                      input logic bz, input logic bs, input logic rd, input logic dn);
    exp_t e;
    e.lbl = lbl; e.led = led; e.buzz = bz; e.busy = bs; e.ready = rd; e.done = dn;
    if (d == 0) begin qa.push_back(e); last_a = lbl; end
    else        begin qb.push_back(e); last_b = lbl; end
  endtask

  task automatic fill_idle(input int d, input int upto);
    int from;
    from = ((d == 0) ? last_a : last_b) + 1;
    if (from < cyc + 1) from = cyc + 1;
    for (int l = from; l <= upto; l++) push(d, l, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_on(input int d, input logic [1:0] c, input int t, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << c;
    for (int k = 1; k <= n; k++)
      push(d, t + k, oh, (((k - 1) / tone_half(d, c)) % 2) != 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_step(input int d, input logic [1:0] c, input int t);
    int on, off;
    on  = on_ticks(d);
    off = off_ticks(d);
    push_on(d, c, t, on);
    for (int k = 1; k <= off; k++) push(d, t + on + k, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(d, t + on + off + 1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic set_in(input int d, input logic v, input logic [1:0] c);
    if (d == 0) begin va = v; ca = c; end
    else        begin vb = v; cb = c; end
  endtask

  task automatic start_step(input int d, input logic [1:0] c, output int t);
    set_in(d, 1'b1, c);
    t = cyc + 1;
    fill_idle(d, t);
    push_step(d, c, t);
  endtask

  task automatic single_step(input int d, input logic [1:0] c, output int t);
    start_step(d, c, t);
    tick();
    set_in(d, 1'b0, c);
  endtask

  task automatic back_to_back(input int d, input logic [1:0] c1, input logic [1:0] c2);
    int t1, t2;
    start_step(d, c1, t1);
    wait_until(t1 + on_ticks(d) + off_ticks(d));
    set_in(d, 1'b1, c2);
    t2 = cyc + 1;
    push_step(d, c2, t2);
    tick();
    set_in(d, 1'b0, c2);
    wait_until(t2 + on_ticks(d) + off_ticks(d) + 1);
    fill_idle(d, cyc + 3);
  endtask

  // Monitor: compares every queued expectation at its labelled cycle
  task automatic check_q(input int d, input string nm);
    exp_t e;
    logic [3:0] led;
    logic bz, bs, rd, dn;
    led = (d == 0) ? led_a : led_b;
    bz  = (d == 0) ? buzz_a : buzz_b;
    bs  = (d == 0) ? busy_a : busy_b;
    rd  = (d == 0) ? ready_a : ready_b;
    dn  = (d == 0) ? done_a : done_b;
    forever begin
      if (d == 0) begin
        if (qa.size() == 0 || qa[0].lbl > mon_lbl) break;
        e = qa.pop_front();
      end else begin
        if (qb.size() == 0 || qb[0].lbl > mon_lbl) break;
        e = qb.pop_front();
      end
      n_tests++;
      if (e.lbl < mon_lbl) begin
        n_fail++;
        $display("FAIL %s stale expectation cycle %0d: checked at %0d, required at %0d",
                 nm, e.lbl, mon_lbl, e.lbl);
      end else if (led !== e.led || bz !== e.buzz || bs !== e.busy ||
                   rd !== e.ready || dn !== e.done) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got led=%b buzz=%b busy=%b ready=%b done=%b, required led=%b buzz=%b busy=%b ready=%b done=%b",
                 nm, mon_lbl, led, bz, bs, rd, dn, e.led, e.buzz, e.busy, e.ready, e.done);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_lbl = cyc + 1;
    check_q(0, "dutA");
    check_q(1, "dutB");
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    va = 1'b0; ca = 2'd0; aa = 1'b0;
    vb = 1'b0; cb = 2'd0; ab = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    fill_idle(0, cyc + 3);
    fill_idle(1, cyc + 3);
    wait_until(cyc + 2);

    // Single step, color 2
    single_step(0, 2'd2, t);
    wait_until(t + 10);
    fill_idle(0, cyc + 3);
    wait_until(cyc + 2);

    // Back-to-back colors 0 then 3
    back_to_back(0, 2'd0, 2'd3);
    wait_until(cyc + 2);

    // Abort in ON cycle 3
    single_step(0, 2'd0, t);
    wait_until(t + 2);
    aa = 1'b1;
    last_a = t + 3;
    while (qa.size() > 0 && qa[qa.size() - 1].lbl > t + 3) void'(qa.pop_back());
    fill_idle(0, t + 14);
    tick();
    aa = 1'b0;
    wait_until(t + 12);

    // Abort together with valid in IDLE blocks acceptance
    aa = 1'b1;
    set_in(0, 1'b1, 2'd1);
    fill_idle(0, cyc + 5);
    tick();
    aa = 1'b0;
    set_in(0, 1'b0, 2'd1);
    wait_until(cyc + 5);

    // Inputs wiggle during ON/GAP; latched color and timing unchanged
    single_step(0, 2'd1, t);
    for (int i = 0; cyc < t + 9; i++) begin
      set_in(0, (i % 2) == 0, 2'($urandom_range(0, 3)));
      tick();
    end
    set_in(0, 1'b0, 2'd0);
    wait_until(t + 10);
    fill_idle(0, cyc + 3);
    wait_until(cyc + 2);

    // Reset mid-ON
    single_step(0, 2'd3, t);
    wait_until(t + 2);
    rst_n = 1'b0;
    last_a = t + 3;
    while (qa.size() > 0 && qa[qa.size() - 1].lbl > t + 3) void'(qa.pop_back());
    fill_idle(0, t + 8);
    fill_idle(1, t + 8);
    tick();
    rst_n = 1'b1;
    wait_until(t + 8);

    // Edge timing: ON=1, OFF=1, TONE_HALF=1
    single_step(1, 2'd2, t);
    wait_until(t + 3);
    fill_idle(1, cyc + 3);
    wait_until(cyc + 2);
    back_to_back(1, 2'd1, 2'd3);

    for (int i = 0; i < 50 && (qa.size() > 0 || qb.size() > 0); i++) tick();
    if (qa.size() > 0 || qb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d unchecked expectations, required 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
